nums_loader: RTL and testbench

Input-collection stage placed directly upstream of the counting sorter. It accepts eight 4-bit numbers one at a time from a user load strobe and packs them into the sorter's 32-bit operand. It then drives the sorter's start/clear level and latches the sorted result for display. It also guards the sorter with a watchdog and returns the sorter to IDLE cleanly on user clear.

---
 rtl/nums_loader.sv | 110 +++++++++++
 tb/tb_nums_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nums_loader.sv
// Collects eight 4-bit numbers from a user load strobe, hands them to the counting
// sorter, guards the sort with a watchdog and latches the sorted result for display.
module nums_loader #(
   parameter int unsigned WD_LIMIT = 63
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  num_i,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [31:0] sorted_nums_i,
   output logic [31:0] nums_o,
   output logic        start_clear_o,
   output logic [3:0]  count_o,
   output logic [31:0] result_o,
   output logic        done_o,
   output logic        err_o
);
   localparam int unsigned NUM_W  = 4;
   localparam int unsigned N_NUMS = 8;
   localparam int unsigned WD_W   = 6;

   typedef enum logic [1:0] {FILL, RUN, SHOW, DRAIN} state_t;

   state_t          state_q;
   logic            load_q;
   logic            clear_q;
   logic [WD_W-1:0] wd_q;
   logic            load_rise;
   logic            clear_rise;

   // Copies reset to 1 so a level held through reset does not count as an edge.
   assign load_rise  = load_i & ~load_q;
   assign clear_rise = clear_i & ~clear_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= FILL;
         load_q        <= 1'b1;
         clear_q       <= 1'b1;
         wd_q          <= '0;
         nums_o        <= '0;
         start_clear_o <= 1'b0;
         count_o       <= '0;
         result_o      <= '0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         load_q  <= load_i;
         clear_q <= clear_i;
         unique case (state_q)
            FILL: begin
               if (clear_rise) begin
                  nums_o  <= '0;
                  count_o <= '0;
                  err_o   <= 1'b0;
               end else if (load_rise) begin
                  nums_o[{count_o[2:0], 2'b00} +: NUM_W] <= num_i;
                  if (count_o == 4'(N_NUMS - 1)) begin
                     count_o       <= 4'(N_NUMS);
                     start_clear_o <= 1'b1;
                     wd_q          <= '0;
                     state_q       <= RUN;
                  end else begin
                     count_o <= count_o + 4'd1;
                  end
               end
            end
            RUN: begin
               wd_q <= wd_q + 1'b1;
               if (valid_i) begin
                  result_o <= sorted_nums_i;
                  done_o   <= 1'b1;
                  state_q  <= SHOW;
               end else if (wd_q == WD_W'(WD_LIMIT) || clear_rise) begin
                  // Abort: release the sorter and discard the operand.
                  if (wd_q == WD_W'(WD_LIMIT)) begin
                     err_o <= 1'b1;
                  end
                  start_clear_o <= 1'b0;
                  nums_o        <= '0;
                  count_o       <= '0;
                  state_q       <= DRAIN;
               end
            end
            SHOW: begin
               if (clear_rise) begin
                  start_clear_o <= 1'b0;
                  done_o        <= 1'b0;
                  result_o      <= '0;
                  nums_o        <= '0;
                  count_o       <= '0;
                  err_o         <= 1'b0;
                  state_q       <= DRAIN;
               end
            end
            DRAIN: begin
               // Wait for the sorter to drop valid before accepting new numbers.
               start_clear_o <= 1'b0;
               if (!valid_i) begin
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_nums_loader.sv
// Bench for nums_loader: directed vector table, multi-cycle corner sequences and
// randomized loads checked against a queue-based reference plus a behavioural sorter.
module tb_nums_loader;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  num_i;
   logic        load_i;
   logic        clear_i;
   logic        valid_i = 1'b0;
   logic [31:0] sorted_nums_i = '0;
   logic [31:0] nums_o;
   logic        start_clear_o;
   logic [3:0]  count_o;
   logic [31:0] result_o;
   logic        done_o;
   logic        err_o;

   int n_vec = 0;
   int n_err = 0;

   logic sorter_en = 1'b1;
   int   lat = 5;
   int   s_cnt = 0;
   int unsigned mq[$];

   typedef struct {
      logic [3:0]  num;
      logic [31:0] exp_nums;
      logic [3:0]  exp_cnt;
      logic        exp_sc;
   } vec_t;
   vec_t tbl[8];

   nums_loader #(.WD_LIMIT(63)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .num_i         (num_i),
      .load_i        (load_i),
      .clear_i       (clear_i),
      .valid_i       (valid_i),
      .sorted_nums_i (sorted_nums_i),
      .nums_o        (nums_o),
      .start_clear_o (start_clear_o),
      .count_o       (count_o),
      .result_o      (result_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Ascending sort of the eight nibbles; smallest value lands in nibble 0.
   function automatic logic [31:0] sort_word(input logic [31:0] w);
      int unsigned q[$];
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) q.push_back(int'(w[4*i +: 4]));
      q.sort();
      for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(q[i]);
      return r;
   endfunction

   function automatic logic [31:0] pack_q();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < mq.size(); i++) r[4*i +: 4] = 4'(mq[i]);
      return r;
   endfunction

   // Behavioural sorter: valid after lat cycles of start, drops one edge after clear.
   always @(posedge clk_i) begin
      if (!start_clear_o) begin
         valid_i <= 1'b0;
         s_cnt   <= 0;
      end else if (sorter_en && !valid_i) begin
         if (s_cnt >= lat) begin
            valid_i       <= 1'b1;
            sorted_nums_i <= sort_word(nums_o);
         end else begin
            s_cnt <= s_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic pulse_load(input logic [3:0] v);
      @(negedge clk_i);
      num_i  = v;
      load_i = 1'b1;
      @(negedge clk_i);
      load_i = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_nums"},   nums_o, 32'h0);
      chk({name, "_count"},  32'(count_o), 32'd0);
      chk({name, "_sc"},     32'(start_clear_o), 32'd0);
      chk({name, "_result"}, result_o, 32'h0);
      chk({name, "_done"},   32'(done_o), 32'd0);
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (!done_o && i < budget) begin
         @(negedge clk_i);
         i++;
      end
      chk("done_within_budget", 32'(done_o), 32'd1);
   endtask

   task automatic load_eight_random();
      mq.delete();
      for (int k = 0; k < 8; k++) begin
         mq.push_back($urandom_range(0, 15));
         pulse_load(4'(mq[k]));
      end
      chk("load8_sc", 32'(start_clear_o), 32'd1);
      chk("load8_nums", nums_o, pack_q());
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{4'h3, 32'h0000_0003, 4'd1, 1'b0};
      tbl[1] = '{4'hF, 32'h0000_00F3, 4'd2, 1'b0};
      tbl[2] = '{4'h0, 32'h0000_00F3, 4'd3, 1'b0};
      tbl[3] = '{4'h7, 32'h0000_70F3, 4'd4, 1'b0};
      tbl[4] = '{4'h7, 32'h0007_70F3, 4'd5, 1'b0};
      tbl[5] = '{4'h1, 32'h0017_70F3, 4'd6, 1'b0};
      tbl[6] = '{4'hC, 32'h0C17_70F3, 4'd7, 1'b0};
      tbl[7] = '{4'h2, 32'h2C17_70F3, 4'd8, 1'b1};

      // Levels held high through reset must not register as edges.
      rst_i = 1'b1; load_i = 1'b1; clear_i = 1'b1; num_i = 4'h9;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk_zero("reset");
      chk("reset_err", 32'(err_o), 32'd0);
      load_i = 1'b0; clear_i = 1'b0;
      @(negedge clk_i);

      // Directed load table; RUN ignores further loads.
      lat = 20;
      for (int i = 0; i < 8; i++) begin
         pulse_load(tbl[i].num);
         chk($sformatf("tbl%0d_nums", i), nums_o, tbl[i].exp_nums);
         chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d_sc", i), 32'(start_clear_o), 32'(tbl[i].exp_sc));
      end
      pulse_load(4'h9);
      chk("run_load_nums", nums_o, 32'h2C17_70F3);
      chk("run_load_count", 32'(count_o), 32'd8);
      wait_done(80);
      chk("show_result", result_o, 32'hFC77_3210);
      chk("show_sc", 32'(start_clear_o), 32'd1);
      pulse_load(4'h4);
      chk("show_load_nums", nums_o, 32'h2C17_70F3);
      chk("show_load_count", 32'(count_o), 32'd8);
      chk("show_hold_result", result_o, 32'hFC77_3210);

      // Clear in SHOW: outputs drop immediately, FILL accepts a load 3 edges later.
      pulse_clear();
      chk_zero("show_clear");
      @(negedge clk_i);
      pulse_load(4'h5);
      chk("fill_reached_count", 32'(count_o), 32'd1);
      chk("fill_reached_nums", nums_o, 32'h0000_0005);

      // Clear and load rising together: clear wins.
      for (int i = 0; i < 4; i++) pulse_load(4'(i + 1));
      chk("five_count", 32'(count_o), 32'd5);
      @(negedge clk_i);
      num_i = 4'h6; load_i = 1'b1; clear_i = 1'b1;
      @(negedge clk_i);
      chk("collide_count", 32'(count_o), 32'd0);
      chk("collide_nums", nums_o, 32'h0);
      load_i = 1'b0; clear_i = 1'b0;

      // Watchdog abort with a silent sorter.
      sorter_en = 1'b0;
      load_eight_random();
      for (int i = 1; i <= 63; i++) begin
         @(negedge clk_i);
         chk("wd_not_yet", 32'(err_o), 32'd0);
      end
      @(negedge clk_i);
      chk("wd_err", 32'(err_o), 32'd1);
      chk("wd_sc", 32'(start_clear_o), 32'd0);
      chk("wd_count", 32'(count_o), 32'd0);
      chk("wd_nums", nums_o, 32'h0);
      @(negedge clk_i);
      pulse_load(4'hA);
      chk("wd_fill_count", 32'(count_o), 32'd1);
      chk("wd_err_sticky", 32'(err_o), 32'd1);
      pulse_clear();
      chk("wd_err_cleared", 32'(err_o), 32'd0);
      chk("wd_clr_count", 32'(count_o), 32'd0);

      // Clear during RUN before the sorter finishes.
      sorter_en = 1'b1; lat = 30;
      load_eight_random();
      repeat (3) @(negedge clk_i);
      pulse_clear();
      chk_zero("run_clear");
      pulse_load(4'h3);
      chk("run_clear_refill", 32'(count_o), 32'd1);
      pulse_clear();

      // Randomized load sessions against the queue model.
      for (int it = 0; it < 30; it++) begin
         int n;
         pulse_clear();
         chk("rnd_start_count", 32'(count_o), 32'd0);
         lat = $urandom_range(0, 30);
         n = $urandom_range(1, 8);
         mq.delete();
         for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            mq.push_back($urandom_range(0, 15));
            pulse_load(4'(mq[k]));
            chk("rnd_count", 32'(count_o), 32'(mq.size()));
            chk("rnd_nums", nums_o, pack_q());
            chk("rnd_sc", 32'(start_clear_o), 32'(k == 7));
         end
         if (n == 8) begin
            wait_done(80);
            chk("rnd_result", result_o, sort_word(pack_q()));
            pulse_clear();
            chk_zero("rnd_show_clear");
            @(negedge clk_i);
         end else begin
            pulse_clear();
            chk("rnd_clr_count", 32'(count_o), 32'd0);
            chk("rnd_clr_nums", nums_o, 32'h0);
         end
         chk("rnd_err", 32'(err_o), 32'd0);
      end

      // Reset asserted mid-fill.
      for (int i = 0; i < 3; i++) pulse_load(4'(i + 7));
      chk("pre_rst_count", 32'(count_o), 32'd3);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk_zero("mid_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
